// File: rtl/ps2_key_tracker.sv
// ps2_key_tracker: pops scan-code bytes from the PS/2 receiver FIFO, decodes
// E0/F0 prefixes, and presents a stable held-key code with a press counter.
module ps2_key_tracker #(
    parameter int CNT_W        = 8,
    parameter bit COUNT_REPEAT = 1'b0
) (
    input  logic             clk,
    input  logic             rst,
    input  logic [7:0]       data,
    input  logic             ready,
    input  logic             overflow,
    output logic             nextdata_n,
    output logic [7:0]       key_code,
    output logic             key_ext,
    output logic             key_down,
    output logic [CNT_W-1:0] press_count,
    output logic             key_event,
    output logic             ovf_flag
);

    localparam logic [7:0] CODE_EXT = 8'hE0;
    localparam logic [7:0] CODE_BRK = 8'hF0;
    localparam logic [7:0] CODE_ERR0 = 8'h00;
    localparam logic [7:0] CODE_ERR1 = 8'hFF;

    typedef enum logic [1:0] {
        S_IDLE,
        S_POP,
        S_PROC
    } state_t;

    state_t           state_q, state_d;
    logic [7:0]       byte_q, byte_d;
    logic             nextdata_n_q, nextdata_n_d;
    logic [7:0]       key_code_q, key_code_d;
    logic             key_ext_q, key_ext_d;
    logic             key_down_q, key_down_d;
    logic [CNT_W-1:0] press_count_q, press_count_d;
    logic             key_event_q, key_event_d;
    logic             ovf_flag_q, ovf_flag_d;
    logic             ext_pend_q, ext_pend_d;
    logic             brk_pend_q, brk_pend_d;
    logic             is_held;

    // The captured byte (with its E0 qualifier) names the key currently held.
    assign is_held = key_down_q && (ext_pend_q == key_ext_q) && (byte_q == key_code_q);

    // Pop handshake sequencing and scan-code decode.
    always_comb begin
        state_d       = state_q;
        byte_d        = byte_q;
        nextdata_n_d  = 1'b1;
        key_code_d    = key_code_q;
        key_ext_d     = key_ext_q;
        key_down_d    = key_down_q;
        press_count_d = press_count_q;
        key_event_d   = 1'b0;
        ovf_flag_d    = ovf_flag_q | overflow;
        ext_pend_d    = ext_pend_q;
        brk_pend_d    = brk_pend_q;

        case (state_q)
            S_IDLE: begin
                if (ready) begin
                    byte_d       = data;
                    nextdata_n_d = 1'b0;
                    state_d      = S_POP;
                end
            end
            // nextdata_n is low for this whole cycle; the receiver advances here.
            S_POP: begin
                state_d = S_PROC;
            end
            S_PROC: begin
                state_d = S_IDLE;
                if (byte_q == CODE_EXT) begin
                    ext_pend_d = 1'b1;
                end else if (byte_q == CODE_BRK) begin
                    brk_pend_d = 1'b1;
                end else begin
                    ext_pend_d = 1'b0;
                    brk_pend_d = 1'b0;
                    if ((byte_q != CODE_ERR0) && (byte_q != CODE_ERR1)) begin
                        if (brk_pend_q) begin
                            // Only a release of the held key matters; others are dropped.
                            if (is_held) begin
                                key_down_d  = 1'b0;
                                key_event_d = 1'b1;
                            end
                        end else if (is_held) begin
                            // Typematic repeat of the held key.
                            if (COUNT_REPEAT) begin
                                press_count_d = press_count_q + CNT_W'(1);
                                key_event_d   = 1'b1;
                            end
                        end else begin
                            // New key press, replacing any held key.
                            key_code_d    = byte_q;
                            key_ext_d     = ext_pend_q;
                            key_down_d    = 1'b1;
                            press_count_d = press_count_q + CNT_W'(1);
                            key_event_d   = 1'b1;
                        end
                    end
                end
            end
            default: begin
                state_d = S_IDLE;
            end
        endcase
    end

    // State registers with synchronous active-low reset.
    always_ff @(posedge clk) begin
        if (!rst) begin
            state_q       <= S_IDLE;
            byte_q        <= 8'h00;
            nextdata_n_q  <= 1'b1;
            key_code_q    <= 8'h00;
            key_ext_q     <= 1'b0;
            key_down_q    <= 1'b0;
            press_count_q <= '0;
            key_event_q   <= 1'b0;
            ovf_flag_q    <= 1'b0;
            ext_pend_q    <= 1'b0;
            brk_pend_q    <= 1'b0;
        end else begin
            state_q       <= state_d;
            byte_q        <= byte_d;
            nextdata_n_q  <= nextdata_n_d;
            key_code_q    <= key_code_d;
            key_ext_q     <= key_ext_d;
            key_down_q    <= key_down_d;
            press_count_q <= press_count_d;
            key_event_q   <= key_event_d;
            ovf_flag_q    <= ovf_flag_d;
            ext_pend_q    <= ext_pend_d;
            brk_pend_q    <= brk_pend_d;
        end
    end

    assign nextdata_n  = nextdata_n_q;
    assign key_code    = key_code_q;
    assign key_ext     = key_ext_q;
    assign key_down    = key_down_q;
    assign press_count = press_count_q;
    assign key_event   = key_event_q;
    assign ovf_flag    = ovf_flag_q;

endmodule

// File: tb/tb_ps2_key_tracker.sv
// Testbench for ps2_key_tracker: FIFO model feeds bytes, a behavioural key
// model predicts each key_event, and a monitor compares on every pulse.
module tb_ps2_key_tracker;

    localparam int CNT_W        = 8;
    localparam bit COUNT_REPEAT = 1'b0;

    logic             clk = 1'b0;
    logic             rst = 1'b0;
    logic [7:0]       data = 8'h00;
    logic             ready = 1'b0;
    logic             overflow = 1'b0;
    logic             nextdata_n;
    logic [7:0]       key_code;
    logic             key_ext;
    logic             key_down;
    logic [CNT_W-1:0] press_count;
    logic             key_event;
    logic             ovf_flag;

    ps2_key_tracker #(.CNT_W(CNT_W), .COUNT_REPEAT(COUNT_REPEAT)) dut (
        .clk(clk), .rst(rst), .data(data), .ready(ready), .overflow(overflow),
        .nextdata_n(nextdata_n), .key_code(key_code), .key_ext(key_ext),
        .key_down(key_down), .press_count(press_count), .key_event(key_event),
        .ovf_flag(ovf_flag)
    );

    always #5 clk = ~clk;

    typedef struct packed {
        logic [7:0]       code;
        logic             ext;
        logic             down;
        logic [CNT_W-1:0] cnt;
    } exp_t;

    int         checks = 0;
    int         errors = 0;
    int         cyc = 0;
    int         low_run = 0;
    logic [7:0] fifo[$];
    exp_t       sb[$];
    int         pop_times[$];
    int         ev_times[$];

    // Reference model of the held-key state, stepped once per byte consumed.
    logic [7:0]       m_code;
    logic             m_ext, m_down, m_ep, m_bp;
    logic [CNT_W-1:0] m_cnt;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] expv);
        checks++;
        if (act !== expv) begin
            errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, expv);
        end
    endtask

    task automatic model_reset();
        m_code = 8'h00; m_ext = 1'b0; m_down = 1'b0;
        m_cnt = '0; m_ep = 1'b0; m_bp = 1'b0;
    endtask

    task automatic model_byte(input logic [7:0] b);
        bit ev;
        bit same;
        ev = 0;
        if (b == 8'hE0) m_ep = 1'b1;
        else if (b == 8'hF0) m_bp = 1'b1;
        else begin
            if (b != 8'h00 && b != 8'hFF) begin
                same = m_down && (m_code == b) && (m_ext == m_ep);
                if (m_bp) begin
                    if (same) begin m_down = 1'b0; ev = 1; end
                end else if (same) begin
                    if (COUNT_REPEAT) begin m_cnt = m_cnt + 1'b1; ev = 1; end
                end else begin
                    m_code = b; m_ext = m_ep; m_down = 1'b1;
                    m_cnt = m_cnt + 1'b1; ev = 1;
                end
            end
            m_ep = 1'b0; m_bp = 1'b0;
        end
        if (ev) sb.push_back('{code: m_code, ext: m_ext, down: m_down, cnt: m_cnt});
    endtask

    // Receiver FIFO model plus scoreboard monitor, both sampled on negedge.
    always @(negedge clk) begin
        logic [7:0] b;
        exp_t e, a;
        cyc++;
        if (nextdata_n === 1'b0) begin
            low_run++;
            if (low_run > 1) chk("pop_single_cycle", low_run, 1);
            if (fifo.size() == 0) chk("pop_while_empty", 1, 0);
            else begin
                b = fifo.pop_front();
                pop_times.push_back(cyc);
                model_byte(b);
            end
        end else low_run = 0;
        ready = (fifo.size() != 0);
        data  = ready ? fifo[0] : 8'h00;
        if (rst === 1'b1 && key_event === 1'b1) begin
            ev_times.push_back(cyc);
            if (sb.size() == 0) chk("unexpected_key_event", 1, 0);
            else begin
                e = sb.pop_front();
                a = '{code: key_code, ext: key_ext, down: key_down, cnt: press_count};
                chk("event_state", a, e);
            end
        end
    end

    task automatic push(input logic [7:0] b);
        fifo.push_back(b);
    endtask

    task automatic push_slot(input logic [7:0] b);
        @(posedge clk); #2;
        fifo.push_back(b);
    endtask

    task automatic wait_idle();
        for (int i = 0; i < 20000 && fifo.size() != 0; i++) @(negedge clk);
        if (fifo.size() != 0) chk("drain_timeout", 1, 0);
        repeat (4) @(negedge clk);
    endtask

    task automatic do_reset();
        @(negedge clk);
        rst = 1'b0;
        model_reset();
        @(negedge clk);
        rst = 1'b1;
    endtask

    task automatic chk_state(input string name, input logic [7:0] c, input logic x,
                             input logic d, input logic [CNT_W-1:0] n);
        chk({name, "_code"}, key_code, c);
        chk({name, "_ext"}, key_ext, x);
        chk({name, "_down"}, key_down, d);
        chk({name, "_count"}, press_count, n);
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1, "watchdog");
    end

    initial begin
        logic [7:0] tbl [10];
        bit         hi_ok;
        int         n;
        tbl = '{8'h1C, 8'h32, 8'h75, 8'h1C, 8'hE0, 8'hF0, 8'hF0, 8'h00, 8'hFF, 8'h75};
        model_reset();
        repeat (3) @(negedge clk);
        rst = 1'b1;

        // Idle with empty FIFO
        hi_ok = 1;
        repeat (20) begin
            @(negedge clk);
            if (nextdata_n !== 1'b1) hi_ok = 0;
        end
        chk("idle_nextdata_n_high", hi_ok, 1);
        chk_state("reset", 8'h00, 1'b0, 1'b0, '0);
        chk("reset_key_event", key_event, 0);
        chk("reset_ovf_flag", ovf_flag, 0);

        // Single press: pop-to-event latency
        pop_times.delete(); ev_times.delete();
        push_slot(8'h1C);
        wait_idle();
        chk("single_pop_count", pop_times.size(), 1);
        chk("single_event_count", ev_times.size(), 1);
        if (pop_times.size() == 1 && ev_times.size() == 1)
            chk("pop_to_event_latency", ev_times[0] - pop_times[0], 2);
        chk_state("press_1c", 8'h1C, 1'b0, 1'b1, 8'd1);

        // Typematic repeats
        ev_times.delete();
        push_slot(8'h1C); push(8'h1C);
        wait_idle();
        chk("repeat_no_event", ev_times.size(), 0);
        chk("repeat_count", press_count, 1);

        // Release
        push_slot(8'hF0); push(8'h1C);
        wait_idle();
        chk("release_event", ev_times.size(), 1);
        chk_state("release_1c", 8'h1C, 1'b0, 1'b0, 8'd1);

        // Extended key and mismatched release
        do_reset();
        push_slot(8'hE0); push(8'h75);
        wait_idle();
        chk_state("ext_press", 8'h75, 1'b1, 1'b1, 8'd1);
        push_slot(8'hF0); push(8'h75);
        wait_idle();
        chk("nonext_break_ignored", key_down, 1);
        ev_times.delete();
        push_slot(8'hE0); push(8'hF0); push(8'h75);
        wait_idle();
        chk("ext_break_event", ev_times.size(), 1);
        chk("ext_break_down", key_down, 0);

        // Rollover, back-to-back pops
        do_reset();
        pop_times.delete(); ev_times.delete();
        push_slot(8'h1C); push(8'h32); push(8'hF0); push(8'h1C); push(8'hF0); push(8'h32);
        wait_idle();
        chk("b2b_pops", pop_times.size(), 6);
        for (int i = 1; i < pop_times.size(); i++)
            chk("b2b_pop_spacing", pop_times[i] - pop_times[i-1], 3);
        chk("b2b_events", ev_times.size(), 3);
        chk_state("b2b_final", 8'h32, 1'b0, 1'b0, 8'd2);

        // Counter wrap
        do_reset();
        for (int i = 0; i < 256; i++) begin
            push_slot(8'h1C); push(8'hF0); push(8'h1C);
            wait_idle();
        end
        chk("wrap_count", press_count, 0);

        // Overflow sticky flag
        @(negedge clk); overflow = 1'b1;
        @(negedge clk); overflow = 1'b0;
        repeat (3) @(negedge clk);
        chk("ovf_set", ovf_flag, 1);
        push_slot(8'h32);
        wait_idle();
        chk("ovf_sticky", ovf_flag, 1);
        chk("press_during_ovf", key_code, 8'h32);
        do_reset();
        @(negedge clk);
        chk("ovf_cleared", ovf_flag, 0);

        // Reset with break prefix pending
        push_slot(8'hF0);
        wait_idle();
        do_reset();
        push_slot(8'h1C);
        wait_idle();
        chk_state("after_mid_reset", 8'h1C, 1'b0, 1'b1, 8'd1);

        // Randomized traffic
        for (int i = 0; i < 400; i++) begin
            n = $urandom_range(1, 3);
            @(posedge clk); #2;
            for (int k = 0; k < n; k++) begin
                if ($urandom_range(0, 7) == 0) push(8'($urandom_range(1, 254)));
                else push(tbl[$urandom_range(0, 9)]);
            end
            repeat ($urandom_range(0, 6)) @(negedge clk);
        end
        wait_idle();
        chk_state("random_final", m_code, m_ext, m_down, m_cnt);
        chk("scoreboard_drained", sb.size(), 0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
